// File: rtl/kryssprodukt_pkg.sv
// Shared constants, types and lane pack/unpack helpers for the kryssprodukt
// datapath and its round-robin sharing wrapper.
package kryssprodukt_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int VEC_W  = LANE_W * LANES;
    localparam int CNT_W  = 16;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] lanes_t;

    // Result register occupancy; the encoding is the res_valid bit itself.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Split {x4,x3,x2,x1} into lanes, x1 at index 0.
    function automatic lanes_t unpack_vec(input logic [VEC_W-1:0] v);
        lanes_t l;
        for (int i = 0; i < LANES; i++) begin
            l[i] = v[i*LANE_W +: LANE_W];
        end
        return l;
    endfunction

    // Inverse of unpack_vec.
    function automatic logic [VEC_W-1:0] pack_vec(input lanes_t l);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v[i*LANE_W +: LANE_W] = l[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/kryssprodukt.sv
// Combinational lane-wise cross product of two packed 3-vectors.
// Lanes 1..3 carry x,y,z; lane 4 is unused on input and produced as zero.
// Each lane result is the low 8 bits of the exact difference of products.
module kryssprodukt
    import kryssprodukt_pkg::*;
(
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    output logic [VEC_W-1:0] c
);

    lanes_t al;
    lanes_t bl;
    lanes_t cl;

    // Cross product computed modulo 2**LANE_W per lane.
    always_comb begin
        al    = unpack_vec(a);
        bl    = unpack_vec(b);
        cl[0] = al[1] * bl[2] - al[2] * bl[1];
        cl[1] = al[2] * bl[0] - al[0] * bl[2];
        cl[2] = al[0] * bl[1] - al[1] * bl[0];
        cl[3] = '0;
        c     = pack_vec(cl);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after ptr,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [2*N-1:0] rotated;
    logic [IW:0]    pos;

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        // NOTE: every output gets a default before the search loop so no path leaves it unassigned (otherwise a latch is inferred).
        grant_idx = ptr;
        grant_any = 1'b0;
        pos       = '0;
        rotated   = {req, req} >> ptr;
        for (int j = 0; j < N; j++) begin
            if (!grant_any && rotated[j]) begin
                pos = {1'b0, ptr} + (IW+1)'(j);
                if (pos >= (IW+1)'(N)) begin
                    pos = pos - (IW+1)'(N);
                end
                grant_idx = pos[IW-1:0];
                grant_any = 1'b1;
            end
        end
        grant = grant_any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/kryssprodukt_arbiter.sv
// Shares one kryssprodukt datapath among N_REQ valid/ready requesters with
// round-robin arbitration and a single registered, id-tagged result port.
// Optional build macro: KRYSSPRODUKT_CNT_EN adds per-requester completed-
// operation counters readable through cnt_sel / cnt_data.
module kryssprodukt_arbiter
    import kryssprodukt_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*VEC_W-1:0] req_a,
    input  logic [N_REQ*VEC_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDW-1:0]         res_id,
    output logic [VEC_W-1:0]       res_c
`ifdef KRYSSPRODUKT_CNT_EN
    ,
    input  logic [IDW-1:0]         cnt_sel,
    output logic [CNT_W-1:0]       cnt_data
`endif
);

    state_t           state;
    state_t           state_d;
    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             can_accept;
    logic             xfer;
    logic [VEC_W-1:0] a_sel;
    logic [VEC_W-1:0] b_sel;
    logic [VEC_W-1:0] kp_c;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Route the granted requester's operands into the shared datapath.
    always_comb begin
        a_sel = req_a[VEC_W-1:0];
        b_sel = req_b[VEC_W-1:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a[i*VEC_W +: VEC_W];
                b_sel = req_b[i*VEC_W +: VEC_W];
            end
        end
    end

    kryssprodukt u_kp (
        .a (a_sel),
        .b (b_sel),
        .c (kp_c)
    );

    // Result-register occupancy state.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_d;
        end
    end

    // Fill on transfer, empty on drain without refill.
    always_comb begin
        state_d = state;
        if (xfer) begin
            state_d = FULL;
        end else if (state == FULL && res_ready) begin
            state_d = EMPTY;
        end
    end

    // Handshake outputs: accept only when the result slot is free or draining.
    always_comb begin
        res_valid  = (state == FULL);
        can_accept = !res_valid || res_ready;
        xfer       = grant_any && can_accept && !rst;
        req_ready  = xfer ? grant : '0;
    end

    // Capture result and owner on transfer; advance the pointer past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_c  <= '0;
            res_id <= '0;
            ptr    <= '0;
        end else if (xfer) begin
            res_c  <= kp_c;
            res_id <= grant_idx;
            ptr    <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

`ifdef KRYSSPRODUKT_CNT_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    // Count completed results per owner; counters wrap naturally.
    always_ff @(posedge clk) begin
        // NOTE: the counter array is architecturally visible after reset, so each entry is cleared explicitly.
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (res_valid && res_ready) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (res_id == IDW'(i)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Combinational counter readback; unused selector codes read zero.
    always_comb begin
        cnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cnt_sel == IDW'(i)) begin
                cnt_data = cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_kryssprodukt_arbiter.sv
// Directed bench for kryssprodukt_arbiter: hand-computed vectors plus a
// scoreboard that checks every result handshake against an independent
// arithmetic model of the cross product.
module tb_kryssprodukt_arbiter;

    localparam int N   = 3;
    localparam int IDW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic [31:0]     res_c;
`ifdef KRYSSPRODUKT_CNT_EN
    logic [IDW-1:0]  cnt_sel;
    logic [15:0]     cnt_data;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Hand-computed results for the three fixed operand pairs below.
    logic [31:0] hand_a [3] = '{32'h0003_0201, 32'h000A_0B0C, 32'h807F_1020};
    logic [31:0] hand_b [3] = '{32'h0006_0504, 32'h0001_0203, 32'h0102_0304};
    logic [31:0] hand_c [3] = '{32'h00FD_06FD, 32'h00F7_12F7, 32'h0020_BCA3};

    kryssprodukt_arbiter #(
        .N_REQ (N),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_c     (res_c)
`ifdef KRYSSPRODUKT_CNT_EN
        ,
        .cnt_sel   (cnt_sel),
        .cnt_data  (cnt_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] kp_model(input logic [31:0] a, input logic [31:0] b);
        int a1 = a[7:0];
        int a2 = a[15:8];
        int a3 = a[23:16];
        int b1 = b[7:0];
        int b2 = b[15:8];
        int b3 = b[23:16];
        int c1 = (a2 * b3 - a3 * b2) & 255;
        int c2 = (a3 * b1 - a1 * b3) & 255;
        int c3 = (a1 * b2 - a2 * b1) & 255;
        return {8'h00, c3[7:0], c2[7:0], c1[7:0]};
    endfunction

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on result handshake, push on operand handshake.
    logic [IDW+31:0] sb [$];
    logic [IDW+31:0] sb_exp;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    sb_exp = sb.pop_front();
                    check("sb_res_id", 64'(res_id), 64'(sb_exp[IDW+31:32]));
                    check("sb_res_c", 64'(res_c), 64'(sb_exp[31:0]));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({IDW'(i), kp_model(req_a[i*32 +: 32], req_b[i*32 +: 32])});
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
`ifdef KRYSSPRODUKT_CNT_EN
        cnt_sel   = '0;
`endif
        for (int i = 0; i < N; i++) set_ops(i, hand_a[i], hand_b[i]);

        // Reset state, with requests present to show ready is gated.
        req_valid = 3'b111;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_c", 64'(res_c), 64'(0));
        check("rst_res_id", 64'(res_id), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));

        // 1: single request from requester 0.
        cyc();
        rst       = 1'b0;
        req_valid = 3'b001;
        res_ready = 1'b1;
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'(3'b001));
        check("t1_res_valid_pre", 64'(res_valid), 64'(0));
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("t1_res_valid", 64'(res_valid), 64'(1));
        check("t1_res_id", 64'(res_id), 64'(0));
        check("t1_res_c_hand", 64'(res_c), 64'(hand_c[0]));
        check("t1_res_c_model", 64'(res_c), 64'(kp_model(hand_a[0], hand_b[0])));
        cyc();
        @(negedge clk);
        check("t1_drained", 64'(res_valid), 64'(0));

        // Reset pulse so the pointer restarts at 0.
        cyc();
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 3'b111;

        // 2: all valid, back-to-back round robin 0,1,2,0,1,2,0.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t2_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
            if (k > 0) begin
                check("t2_res_valid", 64'(res_valid), 64'(1));
                check("t2_res_id", 64'(res_id), 64'((k - 1) % 3));
                check("t2_res_c", 64'(res_c), 64'(hand_c[(k - 1) % 3]));
            end
            cyc();
        end

        // 3: consumer stalls with result 0 held; pointer sits at 1.
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("t3_ready", 64'(req_ready), 64'(0));
            check("t3_res_valid", 64'(res_valid), 64'(1));
            check("t3_res_id", 64'(res_id), 64'(0));
            check("t3_res_c", 64'(res_c), 64'(hand_c[0]));
            cyc();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_resume", 64'(req_ready), 64'(3'b010));
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("t3_res_id", 64'(res_id), 64'(1));
        check("t3_res_c", 64'(res_c), 64'(hand_c[1]));
        cyc();

        // 4: requester 2 alone for four cycles with changing operands.
        req_valid = 3'b100;
        for (int k = 0; k < 4; k++) begin
            set_ops(2, hand_a[2] + 32'(k), hand_b[2] + 32'(k * 32'h0001_0100));
            @(negedge clk);
            check("t4_ready", 64'(req_ready), 64'(3'b100));
            if (k > 0) begin
                check("t4_res_valid", 64'(res_valid), 64'(1));
                check("t4_res_id", 64'(res_id), 64'(2));
            end
            cyc();
        end
        req_valid = 3'b001;
        @(negedge clk);
        check("t4_last_id", 64'(res_id), 64'(2));
        check("t4_then0", 64'(req_ready), 64'(3'b001));
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("t4_res_id0", 64'(res_id), 64'(0));
        cyc();

        // 5: reset while holding a result with 1 and 2 requesting.
        req_valid = 3'b110;
        res_ready = 1'b0;
        @(negedge clk);
        check("t5_ready", 64'(req_ready), 64'(3'b010));
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("t5_full", 64'(res_valid), 64'(1));
        check("t5_rst_ready", 64'(req_ready), 64'(0));
        cyc();
        @(negedge clk);
        check("t5_res_valid", 64'(res_valid), 64'(0));
        check("t5_req_ready", 64'(req_ready), 64'(0));
        check("t5_res_c", 64'(res_c), 64'(0));
        cyc();
        rst       = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("t5_first", 64'(req_ready), 64'(3'b010));
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("t5_res_id", 64'(res_id), 64'(1));
        check("t5_res_c", 64'(res_c), 64'(hand_c[1]));
        cyc();

`ifdef KRYSSPRODUKT_CNT_EN
        // 6: wrap the requester-1 counter.
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 3'b010;
        res_ready = 1'b1;
        repeat (32'h1_0001) cyc();
        req_valid = '0;
        cyc();
        cnt_sel = 2'd1;
        @(negedge clk);
        check("t6_cnt1_wrap", 64'(cnt_data), 64'(16'h0001));
        cyc();
        cnt_sel = 2'd3;
        @(negedge clk);
        check("t6_cnt3", 64'(cnt_data), 64'(16'h0000));
        cyc();
        cnt_sel = 2'd0;
        @(negedge clk);
        check("t6_cnt0", 64'(cnt_data), 64'(16'h0000));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
